bus_arbiter_mux: RTL and testbench
==================================

# bus_arbiter_mux

Parametrised, registered bus multiplexer with round-robin arbitration for the CPU datapath. It connects N word-wide sources (R0..R7, G, din by default) to the shared bus. It has two modes: legacy direct-select, where a controller-driven select picks the source, and arbitrated, where sources raise requests and a round-robin arbiter grants the bus with a bounded hold time. It sits between the register bank/ALU result register and the bus consumers.

## Interface
- WORD, 16, bus and source width in bits
- N, 10, number of sources; source i occupies src_flat[i*WORD +: WORD]; default order R0..R7 = 0..7, G = 8, din = 9
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the bus while others are requesting (>= 1)
- SELW, 4, width of sel/owner; must satisfy 2^SELW > N

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  reset; one clock; reset is asynchronous and active-high
- mode  in  1  0 = direct select, 1 = arbitrated
- sel  in  SELW  source index in direct mode
- req  in  N  per-source bus request, arbitrated mode
- src_flat  in  WORD*N  flattened source words
- grant  out  N  registered one-hot grant; all zero when no owner
- owner  out  SELW  registered index of current/last owner
- bus  out  WORD  registered bus value
- bus_valid  out  1  registered; 1 when bus carries a granted source

## Operation
- Internal state: grant, owner, bus, bus_valid, round-robin pointer ptr (last granted index), hold counter hcnt (0..MAX_HOLD-1).
- Direct mode (mode=0), each edge:
  - if sel < N: grant <= onehot(sel), owner <= sel, bus <= src[sel], bus_valid <= 1
  - else: grant <= 0, bus <= 0, bus_valid <= 0, owner unchanged
  - req is ignored; ptr and hcnt are unchanged
- Arbitrated mode (mode=1), each edge; "others" = req with the owner bit masked:
  - Keep: if the current owner's req=1 and (others==0 or hcnt < MAX_HOLD-1), the grant is kept. hcnt increments; when others==0, hcnt instead saturates at MAX_HOLD-1.
  - Rotate: otherwise, if any req=1, the winner is the first requesting index scanning ptr+1, ptr+2, ... modulo N. A forced release scans from the owner, so the preempted owner ranks last. grant <= onehot(winner), owner <= winner, ptr <= winner, hcnt <= 0.
  - Idle: if req==0, grant <= 0, bus_valid <= 0, bus <= 0; owner and ptr are retained.
  - While granted, bus <= src[owner-after-edge] every edge, so the bus tracks the live source with 1-cycle latency.
- A mode change takes effect at the next edge. Entering arbitration always runs a fresh rotate from ptr, with hcnt = 0.

## Timing
- Reset (asynchronous, immediate): grant=0, owner=0, bus=0, bus_valid=0, ptr=N-1 (so index 0 wins the first contention), hcnt=0.
- Latency, both modes: source/select/request sampled at edge k appears on bus/grant after edge k.
- Owner drops req at edge k: a new winner (or idle) is visible after edge k; there is no dead cycle between owners.
- If all N request continuously, each owner holds exactly MAX_HOLD cycles. Order is 0,1,...,N-1,0.
- MAX_HOLD=1: grant rotates every cycle under contention.
- Reset asserted mid-grant clears all outputs without waiting for a clock. After release, the first grant goes to the lowest requesting index.
- req bits at index >= N do not exist. sel >= N (for example 10..15 with N=10) yields bus=0, bus_valid=0.

## Test plan
- Reset: assert reset mid-operation with no clock -> grant=0, bus=0x0000, bus_valid=0, owner=0 immediately. After release, mode=1, req=0x004 -> after 1 edge grant=0x004, owner=2, bus=src[2].
- Direct mode: mode=0, sel=8, G=0xBEEF -> bus=0xBEEF, bus_valid=1 after 1 edge. sel=12 -> bus=0x0000, bus_valid=0. Toggling req has no effect.
- Round-robin: mode=1, req=0x00B (0,1,3) held, MAX_HOLD=4 -> owner 0 for 4 cycles, then 1 for 4, then 3 for 4, then 0. Each switch is visible on the edge after the 4th held cycle.
- Solo hold: req=0x200 only (din), held 20 cycles -> grant=0x200 for the whole period, never released. bus follows din changes with 1-cycle lag.
- Early release: owner 5 drops req while req=0x041 -> next edge owner=6 (scan from 5), grant=0x040, hcnt=0. Then all req drop -> bus=0, bus_valid=0, owner stays 6.
- Mode switch: in arbitrated mode holding owner 3, set mode=0 with sel=7 -> next edge owner=7, bus=R7. Return to mode=1 with req=0x009 and ptr=3 -> winner 0 (scan from 4).

Source files
------------

// File: rtl/bus_arbiter_mux_if.sv
// Bus-side signal bundle for bus_arbiter_mux: source words, select/request
// inputs and the registered grant/owner/bus outputs.
interface bus_arbiter_mux_if #(
   parameter int WORD = 16,
   parameter int N    = 10,
   parameter int SELW = 4
);
   logic                mode;
   logic [SELW-1:0]     sel;
   logic [N-1:0]        req;
   logic [WORD*N-1:0]   src_flat;
   logic [N-1:0]        grant;
   logic [SELW-1:0]     owner;
   logic [WORD-1:0]     bus;
   logic                bus_valid;

   modport master (
      output mode, sel, req, src_flat,
      input  grant, owner, bus, bus_valid
   );

   modport slave (
      input  mode, sel, req, src_flat,
      output grant, owner, bus, bus_valid
   );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered N-way bus multiplexer: direct select or round-robin arbitration
// with a bounded hold time per owner under contention.
module bus_arbiter_mux #(
   parameter int WORD     = 16,
   parameter int N        = 10,
   parameter int MAX_HOLD = 4,
   parameter int SELW     = 4
) (
   input  logic          clock,
   input  logic          reset,
   bus_arbiter_mux_if.slave bif
);
   localparam int              HW   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0]   HMAX = HW'(MAX_HOLD - 1);
   localparam logic [SELW-1:0] LAST = SELW'(N - 1);

   logic [N-1:0]    r_grant, w_grant;
   logic [SELW-1:0] r_owner, w_owner;
   logic [SELW-1:0] r_ptr, w_ptr;
   logic [WORD-1:0] r_bus, w_bus;
   logic            r_vld, w_vld;
   logic [HW-1:0]   r_hcnt, w_hcnt;
   logic            r_arb;
   logic            w_own_req, w_others, w_found, w_keep;
   logic [SELW-1:0] w_win;

   function automatic logic [WORD-1:0] src_at(input logic [WORD*N-1:0] flat,
                                              input logic [SELW-1:0]   idx);
      src_at = '0;
      for (int i = 0; i < N; i++)
         if (SELW'(i) == idx) src_at = flat[i*WORD +: WORD];
   endfunction

   function automatic logic [N-1:0] onehot(input logic [SELW-1:0] idx);
      onehot = '0;
      for (int i = 0; i < N; i++)
         onehot[i] = (SELW'(i) == idx);
   endfunction

   // Owner/contention decode and round-robin scan starting just after ptr
   always_comb begin
      w_own_req = 1'b0;
      w_others  = 1'b0;
      w_found   = 1'b0;
      w_win     = r_ptr;
      for (int i = 0; i < N; i++) begin
         if (SELW'(i) == r_owner) w_own_req = bif.req[i];
         else if (bif.req[i])     w_others  = 1'b1;
      end
      for (int k = 1; k <= N; k++) begin
         if (!w_found && bif.req[(int'(r_ptr) + k) % N]) begin
            w_found = 1'b1;
            w_win   = SELW'((int'(r_ptr) + k) % N);
         end
      end
      // Only a grant carried over from an arbitrated cycle may be kept
      w_keep = r_arb && r_vld && w_own_req && (!w_others || (r_hcnt < HMAX));
   end

   always_comb begin
      w_grant = r_grant;
      w_owner = r_owner;
      w_ptr   = r_ptr;
      w_bus   = r_bus;
      w_vld   = r_vld;
      w_hcnt  = r_hcnt;
      if (!bif.mode) begin
         if (int'(bif.sel) < N) begin
            w_grant = onehot(bif.sel);
            w_owner = bif.sel;
            w_bus   = src_at(bif.src_flat, bif.sel);
            w_vld   = 1'b1;
         end else begin
            w_grant = '0;
            w_bus   = '0;
            w_vld   = 1'b0;
         end
      end else if (w_keep) begin
         w_hcnt = (w_others || (r_hcnt != HMAX)) ? r_hcnt + 1'b1 : HMAX;
         w_bus  = src_at(bif.src_flat, r_owner);
         w_vld  = 1'b1;
      end else if (w_found) begin
         w_grant = onehot(w_win);
         w_owner = w_win;
         w_ptr   = w_win;
         w_hcnt  = '0;
         w_bus   = src_at(bif.src_flat, w_win);
         w_vld   = 1'b1;
      end else begin
         w_grant = '0;
         w_bus   = '0;
         w_vld   = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_grant <= '0;
         r_owner <= '0;
         r_ptr   <= LAST;
         r_bus   <= '0;
         r_vld   <= 1'b0;
         r_hcnt  <= '0;
         r_arb   <= 1'b0;
      end else begin
         r_grant <= w_grant;
         r_owner <= w_owner;
         r_ptr   <= w_ptr;
         r_bus   <= w_bus;
         r_vld   <= w_vld;
         r_hcnt  <= w_hcnt;
         r_arb   <= bif.mode;
      end
   end

   assign bif.grant     = r_grant;
   assign bif.owner     = r_owner;
   assign bif.bus       = r_bus;
   assign bif.bus_valid = r_vld;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the bus rules.
module tb_bus_arbiter_mux;
   localparam int WORD = 16, N = 10, MAX_HOLD = 4, SELW = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   bus_arbiter_mux_if #(.WORD(WORD), .N(N), .SELW(SELW)) bif ();

   bus_arbiter_mux #(.WORD(WORD), .N(N), .MAX_HOLD(MAX_HOLD), .SELW(SELW)) dut (
      .clock (clock),
      .reset (reset),
      .bif   (bif)
   );

   int tests = 0;
   int fails = 0;

   logic [WORD-1:0] src [N];

   // reference model state
   logic [N-1:0]    m_grant;
   int              m_owner, m_ptr, m_hcnt;
   logic [WORD-1:0] m_bus;
   bit              m_vld, m_arb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < N; i++) bif.src_flat[i*WORD +: WORD] = src[i];
   endtask

   task automatic drive(input bit md, input int s, input int rq);
      bif.mode = md;
      bif.sel  = s[SELW-1:0];
      bif.req  = rq[N-1:0];
   endtask

   task automatic model_reset();
      m_grant = '0; m_owner = 0; m_bus = '0; m_vld = 0;
      m_ptr = N - 1; m_hcnt = 0; m_arb = 0;
   endtask

   task automatic model_edge();
      int  s, oth, w;
      bit  keep, done;
      if (!bif.mode) begin
         s = int'(bif.sel);
         if (s < N) begin
            m_grant = '0; m_grant[s] = 1'b1;
            m_owner = s; m_bus = src[s]; m_vld = 1;
         end else begin
            m_grant = '0; m_bus = '0; m_vld = 0;
         end
      end else begin
         oth = 0;
         for (int i = 0; i < N; i++) if (i != m_owner && bif.req[i]) oth++;
         keep = m_arb && m_vld && bif.req[m_owner] && (oth == 0 || m_hcnt < MAX_HOLD - 1);
         if (keep) begin
            m_hcnt = (oth == 0) ? ((m_hcnt + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_hcnt + 1)
                                : m_hcnt + 1;
            m_bus = src[m_owner];
            m_vld = 1;
         end else if (bif.req != '0) begin
            done = 0;
            for (int k = 1; k <= N; k++) begin
               w = (m_ptr + k) % N;
               if (!done && bif.req[w]) begin
                  done = 1;
                  m_owner = w; m_ptr = w; m_hcnt = 0;
                  m_grant = '0; m_grant[w] = 1'b1;
                  m_bus = src[w]; m_vld = 1;
               end
            end
         end else begin
            m_grant = '0; m_bus = '0; m_vld = 0;
         end
      end
      m_arb = bif.mode;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".grant"}, 32'(bif.grant), 32'(m_grant));
      chk({tag, ".owner"}, 32'(bif.owner), 32'(m_owner));
      chk({tag, ".bus"},   32'(bif.bus),   32'(m_bus));
      chk({tag, ".valid"}, 32'(bif.bus_valid), 32'(m_vld));
   endtask

   task automatic step(input string tag);
      pack();
      model_edge();
      @(posedge clock);
      #1;
      check_all(tag);
   endtask

   // asynchronous reset between edges, checked before any clock edge
   task automatic do_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   int rr [3] = '{0, 1, 3};
   int cur_req;

   initial begin
      for (int i = 0; i < N; i++) src[i] = WORD'($urandom);
      drive(0, 0, 0);
      pack();
      @(posedge clock);
      #1;
      do_reset("rst_init");

      // busy traffic, then reset mid-grant
      drive(1, 0, 'h3FF);
      for (int i = 0; i < 3; i++) step("pre_rst");
      do_reset("rst_mid");
      chk("rst_mid_bus_const", 32'(bif.bus), 32'h0);
      drive(1, 0, 'h004);
      step("rst_first");
      chk("rst_first_grant", 32'(bif.grant), 32'h004);
      chk("rst_first_owner", 32'(bif.owner), 32'd2);
      chk("rst_first_bus",   32'(bif.bus),   32'(src[2]));

      // direct select
      src[8] = 16'hBEEF;
      drive(0, 8, 0);
      step("dir_g");
      chk("dir_g_bus", 32'(bif.bus), 32'hBEEF);
      chk("dir_g_vld", 32'(bif.bus_valid), 32'h1);
      drive(0, 12, 0);
      step("dir_oob");
      chk("dir_oob_bus", 32'(bif.bus), 32'h0);
      chk("dir_oob_vld", 32'(bif.bus_valid), 32'h0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 8, int'($urandom_range(0, 1023)));
         step("dir_req_ign");
         chk("dir_req_ign_bus", 32'(bif.bus), 32'hBEEF);
      end

      // round-robin among 0,1,3 with full hold
      do_reset("rst_rr");
      drive(1, 0, 'h00B);
      for (int j = 0; j < 14; j++) begin
         step("rr");
         chk("rr_owner_seq", 32'(bif.owner), 32'(rr[(j / 4) % 3]));
      end

      // solo requester never released, bus follows live source
      drive(1, 0, 'h200);
      for (int j = 0; j < 20; j++) begin
         src[9] = WORD'($urandom);
         step("solo");
         chk("solo_grant", 32'(bif.grant), 32'h200);
      end

      // early release by owner 5
      drive(1, 0, 'h020);
      step("er_own5");
      chk("er_own5_owner", 32'(bif.owner), 32'd5);
      drive(1, 0, 'h041);
      step("er_next");
      chk("er_next_owner", 32'(bif.owner), 32'd6);
      chk("er_next_grant", 32'(bif.grant), 32'h040);
      drive(1, 0, 'h000);
      step("er_idle");
      chk("er_idle_vld",   32'(bif.bus_valid), 32'h0);
      chk("er_idle_owner", 32'(bif.owner), 32'd6);

      // mode switch round trip
      drive(1, 0, 'h008);
      step("ms_own3");
      chk("ms_own3_owner", 32'(bif.owner), 32'd3);
      drive(0, 7, 'h008);
      step("ms_dir7");
      chk("ms_dir7_owner", 32'(bif.owner), 32'd7);
      chk("ms_dir7_bus",   32'(bif.bus),   32'(src[7]));
      drive(1, 0, 'h009);
      step("ms_back");
      chk("ms_back_owner", 32'(bif.owner), 32'd0);

      // randomized traffic
      cur_req = 'h3FF;
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 99) < 2) begin
            do_reset("rnd_rst");
         end else begin
            if ($urandom_range(0, 99) < 30)
               cur_req = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 3) == 0) src[i] = WORD'($urandom);
            drive($urandom_range(0, 9) != 0, int'($urandom_range(0, 15)), cur_req);
            step("rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
